// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a per-register scoreboard.
//
// Decode reads operands and their busy status combinationally; issue allocates a
// destination (busy set); writeback commits data and clears busy.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears data, busy bits, pending count)
//   rd_addr      NRD read addresses, port i at [i*AW +: AW]
//   rd_data      NRD read data words, port i at [i*XLEN +: XLEN]
//   rd_busy      per read port: addressed register has a pending producer
//   wr_en        per write port enable
//   wr_addr      NWR write addresses
//   wr_data      NWR write data words
//   alloc_en     mark alloc_addr busy at the next edge
//   alloc_addr   destination register being allocated
//   flush        clear all busy bits at the next edge (data writes still happen)
//   pending_cnt  registered popcount of the busy vector
//
// Handshake: there is no valid/ready flow control here. Reads are combinational and
// always valid; wr_en/alloc_en/flush are single-cycle strobes sampled on the rising edge.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [AW:0]         pending_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     pending_cnt_q, pending_cnt_d;

  // An address is real storage if it lies below NREG and is not the hard-wired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = ({1'b0, a} < (AW+1)'(NREG)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Next state. Loop order gives the highest write port priority on address clashes;
  // alloc is applied after the writes so a new producer keeps the register busy;
  // flush is applied last so it overrides a same-cycle alloc.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && addr_ok(wr_addr[j*AW +: AW])) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    // Allocating an already busy register is a legal WAW rename; busy simply stays 1.
    if (alloc_en && addr_ok(alloc_addr)) begin
      busy_d[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    pending_cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      pending_cnt_d = pending_cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  // Combinational read with optional same-cycle bypass. The bypass is gated by rst_n so
  // the read ports show zero for as long as reset is held.
  logic [AW-1:0]   ra;
  logic            hit;
  logic [XLEN-1:0] byp_data;

  always_comb begin
    rd_data  = '0;
    rd_busy  = '0;
    ra       = '0;
    hit      = 1'b0;
    byp_data = '0;
    for (int i = 0; i < NRD; i++) begin
      ra       = rd_addr[i*AW +: AW];
      hit      = 1'b0;
      byp_data = '0;
      if ((BYPASS != 0) && rst_n) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
            hit      = 1'b1;
            byp_data = wr_data[j*XLEN +: XLEN];
          end
        end
      end
      if (addr_ok(ra)) begin
        rd_data[i*XLEN +: XLEN] = hit ? byp_data : regs_q[ra];
        rd_busy[i]              = busy_q[ra] & ~hit;
      end
    end
  end

  assign pending_cnt = pending_cnt_q;

endmodule
